// File: rtl/vga_pkg.sv
// Shared constants and types for the 800x600 @ 40 MHz VGA pipeline.
//
// Contents:
//   HOR_PIXELS / VER_PIXELS  visible area
//   HOR_TOTAL / VER_TOTAL    full line / frame length including blanking
//   rgb_t                    12-bit RGB444 colour
//   COMMIT_H / COMMIT_V      pixel at which pending rectangle moves are applied
//                            (first pixel of vertical blank)
//   clamp12()                saturating clamp of an 11-bit position to a limit
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
  localparam int HOR_TOTAL  = 1056;
  localparam int VER_TOTAL  = 628;

  typedef logic [11:0] rgb_t;

  // Start of vertical blank: line VER_PIXELS, pixel 0.
  localparam logic [10:0] COMMIT_H = 11'd0;
  localparam logic [10:0] COMMIT_V = 11'(VER_PIXELS);

  // Widen to 12 bits so large requests (up to 2047) compare correctly.
  function automatic logic [11:0] clamp12(input logic [10:0] pos, input logic [11:0] lim);
    logic [11:0] p12;
    p12 = {1'b0, pos};
    return (p12 > lim) ? lim : p12;
  endfunction

endpackage

// File: rtl/delay.sv
// Fixed-length register delay line with asynchronous active-low reset.
//
// Parameters:
//   WIDTH    bit width of the delayed bus
//   CLK_DEL  number of clock cycles of delay (>= 1)
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset, clears every stage to 0
//   din_i   bus to delay
//   dout_o  din_i delayed by CLK_DEL cycles
module delay #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [CLK_DEL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CLK_DEL; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < CLK_DEL; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[CLK_DEL-1];

endmodule

// File: rtl/draw_rect.sv
// Rectangle overlay stage for the 800x600 VGA pipeline.
//
// Sits directly after vga_timing. Draws a RECT_W x RECT_H rectangle of
// RECT_COLOR over the upstream background at a software-controlled position.
// Position requests use a valid/ready handshake; accepted requests wait in a
// shadow register and are applied at the first pixel of vertical blank so a
// visible frame never shows two positions. All outputs lag inputs by 2 clocks.
//
// Handshake: a request transfers on a rising edge where pos_valid && pos_ready.
// pos_ready is low while a request is pending and returns high the cycle after
// the commit pixel. The requester may change pos_x/pos_y freely while
// pos_ready is low; only the value present at the transfer edge is used.
//
// Optional build macro DRAW_RECT_BORDER_EN: draw only a 2-pixel outline
// (requires RECT_W >= 4 and RECT_H >= 4). Undefined: filled rectangle.
//
// Ports:
//   clk, rst_n                 40 MHz pixel clock, async active-low reset
//   hcount_in, vcount_in       counters from vga_timing
//   hsync_in, vsync_in         syncs
//   hblnk_in, vblnk_in         blanking flags
//   rgb_in                     background colour aligned with the counters
//   pos_x, pos_y, pos_valid    position request
//   pos_ready                  request can be accepted
//   *_out                      timing signals delayed 2 cycles
//   rgb_out                    composed pixel colour (0 during blanking)
module draw_rect
  import vga_pkg::*;
#(
  parameter int   RECT_W     = 64,
  parameter int   RECT_H     = 48,
  parameter rgb_t RECT_COLOR = 12'hF00,
  parameter int   X_INIT     = 0,
  parameter int   Y_INIT     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] pos_x,
  input  logic [10:0] pos_y,
  input  logic        pos_valid,
  output logic        pos_ready,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [11:0] W12    = 12'(RECT_W);
  localparam logic [11:0] H12    = 12'(RECT_H);
  localparam logic [11:0] X_MAX  = 12'(HOR_PIXELS - RECT_W);
  localparam logic [11:0] Y_MAX  = 12'(VER_PIXELS - RECT_H);
  localparam logic [11:0] AX_RST = 12'(X_INIT);
  localparam logic [11:0] AY_RST = 12'(Y_INIT);

  // ---------------------------------------------------------------------------
  // Position control: shadow register + pending flag, applied at commit pixel
  // ---------------------------------------------------------------------------
  logic        pending_q, pending_d;
  logic [11:0] shadow_x_q, shadow_x_d;
  logic [11:0] shadow_y_q, shadow_y_d;
  logic [11:0] ax_q, ax_d;
  logic [11:0] ay_q, ay_d;
  logic        commit;
  logic        accept;

  always_comb begin
    commit     = (vcount_in == COMMIT_V) && (hcount_in == COMMIT_H);
    accept     = pos_valid && !pending_q;
    pending_d  = pending_q;
    shadow_x_d = shadow_x_q;
    shadow_y_d = shadow_y_q;
    ax_d       = ax_q;
    ay_d       = ay_q;
    if (commit && pending_q) begin
      ax_d      = shadow_x_q;
      ay_d      = shadow_y_q;
      pending_d = 1'b0;
    end
    // Accept only happens when not pending, so it never collides with a
    // commit; a request taken on the commit pixel waits for the next frame.
    if (accept) begin
      shadow_x_d = clamp12(pos_x, X_MAX);
      shadow_y_d = clamp12(pos_y, Y_MAX);
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= 1'b0;
      shadow_x_q <= '0;
      shadow_y_q <= '0;
      ax_q       <= AX_RST;
      ay_q       <= AY_RST;
    end else begin
      pending_q  <= pending_d;
      shadow_x_q <= shadow_x_d;
      shadow_y_q <= shadow_y_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
    end
  end

  assign pos_ready = !pending_q;

  // ---------------------------------------------------------------------------
  // Stage 1: rectangle hit test and blanking
  // ---------------------------------------------------------------------------
  logic [11:0] h12, v12;
  logic        in_rect;
  logic        draw_d, draw_q;
  logic        blank_d, blank_q;
  logic [11:0] rgb_s1_q;

`ifdef DRAW_RECT_BORDER_EN
  // Distances to each edge; only meaningful (no wrap) when in_rect is true.
  logic [11:0] dx_lo, dx_hi, dy_lo, dy_hi;
`endif

  always_comb begin
    h12     = {1'b0, hcount_in};
    v12     = {1'b0, vcount_in};
    in_rect = (h12 >= ax_q) && (h12 < ax_q + W12) &&
              (v12 >= ay_q) && (v12 < ay_q + H12);
    blank_d = hblnk_in || vblnk_in;
`ifdef DRAW_RECT_BORDER_EN
    dx_lo  = h12 - ax_q;
    dx_hi  = ax_q + W12 - 12'd1 - h12;
    dy_lo  = v12 - ay_q;
    dy_hi  = ay_q + H12 - 12'd1 - v12;
    draw_d = in_rect && ((dx_lo < 12'd2) || (dx_hi < 12'd2) ||
                         (dy_lo < 12'd2) || (dy_hi < 12'd2));
`else
    draw_d = in_rect;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      draw_q   <= 1'b0;
      blank_q  <= 1'b0;
      rgb_s1_q <= '0;
    end else begin
      draw_q   <= draw_d;
      blank_q  <= blank_d;
      rgb_s1_q <= rgb_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour mux
  // ---------------------------------------------------------------------------
  logic [11:0] rgb_out_q, rgb_out_d;

  always_comb begin
    rgb_out_d = rgb_s1_q;
    if (blank_q)     rgb_out_d = '0;
    else if (draw_q) rgb_out_d = RECT_COLOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_out_q <= '0;
    else        rgb_out_q <= rgb_out_d;
  end

  assign rgb_out = rgb_out_q;

  // ---------------------------------------------------------------------------
  // Timing signals: 2-cycle delay line matching the colour path
  // ---------------------------------------------------------------------------
  logic [25:0] timing_in, timing_out;

  assign timing_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

  delay #(
    .WIDTH  (26),
    .CLK_DEL(2)
  ) u_timing_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din_i (timing_in),
    .dout_o(timing_out)
  );

  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = timing_out;

endmodule

// File: tb/tb_draw_rect.sv
`timescale 1ns/1ps
module tb_draw_rect;

  localparam int          RECT_W     = 64;
  localparam int          RECT_H     = 48;
  localparam logic [11:0] RECT_COLOR = 12'hF00;
  localparam int          X_INIT     = 0;
  localparam int          Y_INIT     = 0;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #12 clk = ~clk;

  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] pos_x = '0, pos_y = '0;
  logic        pos_valid = 1'b0;
  logic        pos_ready;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_rect #(
    .RECT_W    (RECT_W),
    .RECT_H    (RECT_H),
    .RECT_COLOR(RECT_COLOR),
    .X_INIT    (X_INIT),
    .Y_INIT    (Y_INIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hcount_in (hcount_in),
    .vcount_in (vcount_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .hblnk_in  (hblnk_in),
    .vblnk_in  (vblnk_in),
    .rgb_in    (rgb_in),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .pos_valid (pos_valid),
    .pos_ready (pos_ready),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .hblnk_out (hblnk_out),
    .vblnk_out (vblnk_out),
    .rgb_out   (rgb_out)
  );

  // ---------------------------------------------------------------------------
  // Reference model state and scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  logic in_rst    = 1'b1;
  logic req_valid = 1'b0;
  int   req_x     = 0;
  int   req_y     = 0;

  // Active rectangle origin, and accepted-but-not-yet-shown moves (x*4096+y).
  int m_ax = X_INIT;
  int m_ay = Y_INIT;
  int pend_q[$];

  // {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}
  logic [37:0] exp_q[$];

  function automatic int clamp_x(input int x);
    return (x > 800 - RECT_W) ? 800 - RECT_W : x;
  endfunction

  function automatic int clamp_y(input int y);
    return (y > 600 - RECT_H) ? 600 - RECT_H : y;
  endfunction

  // Background colours never equal RECT_COLOR.
  function automatic logic [11:0] bg_color();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    return {4'h0, b};
  endfunction

  function automatic logic [11:0] model_pixel(input int h, input int v, input logic [11:0] bg);
    logic hit;
    if (h >= 800 || v >= 600) return 12'h000;
    hit = (h >= m_ax) && (h < m_ax + RECT_W) && (v >= m_ay) && (v < m_ay + RECT_H);
`ifdef DRAW_RECT_BORDER_EN
    hit = hit && ((h - m_ax < 2) || (m_ax + RECT_W - 1 - h < 2) ||
                  (v - m_ay < 2) || (m_ay + RECT_H - 1 - v < 2));
`endif
    return hit ? RECT_COLOR : bg;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one pixel per call. At the falling edge it first compares the
  // DUT outputs with the scoreboard entry from two calls earlier, then drives
  // the new pixel and advances the model across the coming rising edge.
  // ---------------------------------------------------------------------------
  task automatic drive_pixel(input int h, input int v, input logic [11:0] rgb,
                             output logic [11:0] obs_rgb, output logic obs_ready);
    logic [37:0] got, exp;
    logic [10:0] hv, vv;
    logic        hs, vs, hb, vb, exp_ready, acc;
    int          p;
    @(negedge clk);
    obs_rgb   = rgb_out;
    obs_ready = pos_ready;
    got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
    exp = (exp_q.size() == 2) ? exp_q.pop_front() : 38'h0;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL scoreboard t=%0t: got %h expected %h", $time, got, exp);
    end
    exp_ready = (pend_q.size() == 0);
    checks++;
    if (pos_ready !== exp_ready) begin
      errors++;
      $display("FAIL pos_ready t=%0t: got %b expected %b", $time, pos_ready, exp_ready);
    end

    hv = h[10:0];
    vv = v[10:0];
    hs = (h >= 840) && (h < 968);
    vs = (v >= 601) && (v < 605);
    hb = (h >= 800);
    vb = (v >= 600);
    rst_n     = !in_rst;
    hcount_in = hv;
    vcount_in = vv;
    hsync_in  = hs;
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = rgb;
    pos_valid = req_valid;
    pos_x     = req_x[10:0];
    pos_y     = req_y[10:0];

    if (!in_rst) begin
      exp_q.push_back({hv, vv, hs, vs, hb, vb, model_pixel(h, v, rgb)});
      acc = req_valid && (pend_q.size() == 0);
      if (h == 0 && v == 600 && pend_q.size() > 0) begin
        p = pend_q.pop_front();
        m_ax = p / 4096;
        m_ay = p % 4096;
      end
      if (acc) pend_q.push_back(clamp_x(req_x) * 4096 + clamp_y(req_y));
    end
  endtask

  // Drive a pixel and return the colour it produces two cycles later.
  task automatic probe(input int h, input int v, input logic [11:0] rgb, output logic [11:0] obs);
    logic [11:0] d;
    logic        r;
    drive_pixel(h, v, rgb, d, r);
    drive_pixel(1000, 10, 12'h5A5, d, r);
    drive_pixel(1000, 10, 12'h5A5, obs, r);
  endtask

  task automatic apply_reset(input int cycles, input int h, input int v);
    logic [11:0] d;
    logic        r;
    @(negedge clk);
    rst_n  = 1'b0;
    in_rst = 1'b1;
    exp_q.delete();
    pend_q.delete();
    m_ax = X_INIT;
    m_ay = Y_INIT;
    #1;
    checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== 38'h0 ||
        pos_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: outputs %h ready %b, expected 0 and 1",
               {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out}, pos_ready);
    end
    repeat (cycles - 1) drive_pixel(h, v, bg_color(), d, r);
    in_rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [11:0] d;
    logic        r;
    apply_reset(3, 0, 0);
    drive_pixel(0, 0, 12'h00F, d, r);
    checks++;
    if (r !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", r); end
  endtask

  task automatic test_default_rect();
    logic [11:0] o;
    probe(0, 0, 12'h00F, o);
    checks++; if (o !== RECT_COLOR) begin errors++; $display("FAIL default_origin: got %h expected %h", o, RECT_COLOR); end
    probe(64, 0, 12'h00F, o);
    checks++; if (o !== 12'h00F) begin errors++; $display("FAIL default_right_edge: got %h expected 00f", o); end
    probe(63, 47, 12'h00F, o);
    checks++; if (o !== RECT_COLOR) begin errors++; $display("FAIL default_corner: got %h expected %h", o, RECT_COLOR); end
    probe(0, 48, 12'h00F, o);
    checks++; if (o !== 12'h00F) begin errors++; $display("FAIL default_bottom_edge: got %h expected 00f", o); end
    probe(900, 10, 12'h00F, o);
    checks++; if (o !== 12'h000) begin errors++; $display("FAIL hblank_black: got %h expected 000", o); end
    probe(10, 610, 12'h00F, o);
    checks++; if (o !== 12'h000) begin errors++; $display("FAIL vblank_black: got %h expected 000", o); end
  endtask

  task automatic test_mid_frame_request();
    logic [11:0] o, d, bg;
    logic        r;
    bg = bg_color();
    req_valid = 1'b1; req_x = 100; req_y = 200;
    drive_pixel(500, 300, bg, d, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL mid_ready_before: got %b expected 1", r); end
    req_valid = 1'b0;
    drive_pixel(501, 300, bg, d, r);
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL mid_ready_low: got %b expected 0", r); end
    probe(10, 10, bg, o);
    checks++; if (o !== RECT_COLOR) begin errors++; $display("FAIL mid_old_pos_kept: got %h expected %h", o, RECT_COLOR); end
    probe(100, 200, bg, o);
    checks++; if (o !== bg) begin errors++; $display("FAIL mid_new_pos_early: got %h expected %h", o, bg); end
    drive_pixel(0, 600, bg, d, r);
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL mid_ready_at_commit: got %b expected 0", r); end
    drive_pixel(1, 600, bg, d, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL mid_ready_after_commit: got %b expected 1", r); end
    probe(100, 200, bg, o);
    checks++; if (o !== RECT_COLOR) begin errors++; $display("FAIL mid_new_origin: got %h expected %h", o, RECT_COLOR); end
    probe(99, 200, bg, o);
    checks++; if (o !== bg) begin errors++; $display("FAIL mid_left_of_origin: got %h expected %h", o, bg); end
  endtask

  task automatic test_clamp();
    logic [11:0] o, d, bg;
    logic        r;
    bg = bg_color();
    req_valid = 1'b1; req_x = 790; req_y = 590;
    drive_pixel(5, 5, bg, d, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL clamp_ready: got %b expected 1", r); end
    req_valid = 1'b0;
    drive_pixel(0, 600, bg, d, r);
    probe(799, 599, bg, o);
    checks++; if (o !== RECT_COLOR) begin errors++; $display("FAIL clamp_last_pixel: got %h expected %h", o, RECT_COLOR); end
    probe(736, 552, bg, o);
    checks++; if (o !== RECT_COLOR) begin errors++; $display("FAIL clamp_origin: got %h expected %h", o, RECT_COLOR); end
    probe(735, 552, bg, o);
    checks++; if (o !== bg) begin errors++; $display("FAIL clamp_left: got %h expected %h", o, bg); end
    probe(736, 551, bg, o);
    checks++; if (o !== bg) begin errors++; $display("FAIL clamp_above: got %h expected %h", o, bg); end
    probe(800, 599, bg, o);
    checks++; if (o !== 12'h000) begin errors++; $display("FAIL clamp_hblank: got %h expected 000", o); end
    probe(799, 600, bg, o);
    checks++; if (o !== 12'h000) begin errors++; $display("FAIL clamp_vblank: got %h expected 000", o); end
  endtask

  task automatic test_hold_valid();
    logic [11:0] o, d;
    logic        r;
    int          acc_x, acc_y;
    req_valid = 1'b1;
    req_x = $urandom_range(0, 2047); req_y = $urandom_range(0, 2047);
    drive_pixel(20, 20, bg_color(), d, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL hold_first_ready: got %b expected 1", r); end
    acc_x = clamp_x(req_x); acc_y = clamp_y(req_y);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 20; i++) begin
        req_x = $urandom_range(0, 2047); req_y = $urandom_range(0, 2047);
        drive_pixel($urandom_range(0, 799), $urandom_range(0, 599), bg_color(), d, r);
        checks++; if (r !== 1'b0) begin errors++; $display("FAIL hold_ready_low f%0d: got %b expected 0", f, r); end
      end
      drive_pixel(0, 600, bg_color(), d, r);
      if (f == 2) begin req_x = 0; req_y = 0; end
      else begin req_x = $urandom_range(0, 2047); req_y = $urandom_range(0, 2047); end
      drive_pixel(2, 600, bg_color(), d, r);
      checks++; if (r !== 1'b1) begin errors++; $display("FAIL hold_ready_after_commit f%0d: got %b expected 1", f, r); end
      probe(acc_x, acc_y, bg_color(), o);
      checks++; if (o !== RECT_COLOR) begin errors++; $display("FAIL hold_new_origin f%0d: got %h expected %h", f, o, RECT_COLOR); end
      acc_x = clamp_x(req_x); acc_y = clamp_y(req_y);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_commit_cycle_accept();
    logic [11:0] o, d, bg;
    logic        r;
    bg = bg_color();
    drive_pixel(0, 600, bg, d, r);
    drive_pixel(5, 601, bg, d, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL cc_ready_idle: got %b expected 1", r); end
    req_valid = 1'b1; req_x = 300; req_y = 300;
    drive_pixel(0, 600, bg, d, r);
    req_valid = 1'b0;
    drive_pixel(1, 600, bg, d, r);
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL cc_held_ready: got %b expected 0", r); end
    probe(300, 300, bg, o);
    checks++; if (o !== bg) begin errors++; $display("FAIL cc_not_applied: got %h expected %h", o, bg); end
    probe(10, 10, bg, o);
    checks++; if (o !== RECT_COLOR) begin errors++; $display("FAIL cc_old_pos: got %h expected %h", o, RECT_COLOR); end
    drive_pixel(0, 600, bg, d, r);
    probe(300, 300, bg, o);
    checks++; if (o !== RECT_COLOR) begin errors++; $display("FAIL cc_applied_next: got %h expected %h", o, RECT_COLOR); end
  endtask

  task automatic test_random();
    logic [11:0] d;
    logic        r;
    int          h, v;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 150; i++) begin
        req_valid = ($urandom_range(0, 9) == 0);
        req_x = $urandom_range(0, 2047);
        req_y = $urandom_range(0, 2047);
        if ($urandom_range(0, 2) == 0) begin
          h = $urandom_range(0, 1055);
          v = $urandom_range(0, 627);
        end else begin
          h = m_ax + $urandom_range(0, RECT_W + 3) - 2;
          v = m_ay + $urandom_range(0, RECT_H + 3) - 2;
          if (h < 0) h = 0;
          if (v < 0) v = 0;
        end
        drive_pixel(h, v, bg_color(), d, r);
      end
      req_valid = 1'b0;
      drive_pixel(0, 600, bg_color(), d, r);
      drive_pixel(1, 600, bg_color(), d, r);
    end
  endtask

  task automatic test_mid_reset();
    logic [11:0] o, d, bg;
    logic        r;
    bg = bg_color();
    req_valid = 1'b1; req_x = 200; req_y = 100;
    drive_pixel(5, 5, bg, d, r);
    req_valid = 1'b0;
    drive_pixel(0, 600, bg, d, r);
    req_valid = 1'b1; req_x = 50; req_y = 50;
    drive_pixel(6, 6, bg, d, r);
    req_valid = 1'b0;
    drive_pixel(400, 100, bg, d, r);
    apply_reset(3, 400, 100);
    drive_pixel(400, 100, bg, d, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", r); end
    probe(0, 0, bg, o);
    checks++; if (o !== RECT_COLOR) begin errors++; $display("FAIL rst_init_pos: got %h expected %h", o, RECT_COLOR); end
    probe(200, 100, bg, o);
    checks++; if (o !== bg) begin errors++; $display("FAIL rst_old_pos_gone: got %h expected %h", o, bg); end
    drive_pixel(0, 600, bg, d, r);
    probe(50, 50, bg, o);
    checks++; if (o !== bg) begin errors++; $display("FAIL rst_pending_cleared: got %h expected %h", o, bg); end
  endtask

`ifdef DRAW_RECT_BORDER_EN
  task automatic test_border();
    logic [11:0] o, bg;
    bg = bg_color();
    probe(0, 0, bg, o);
    checks++; if (o !== RECT_COLOR) begin errors++; $display("FAIL border_0_0: got %h expected %h", o, RECT_COLOR); end
    probe(1, 10, bg, o);
    checks++; if (o !== RECT_COLOR) begin errors++; $display("FAIL border_1_10: got %h expected %h", o, RECT_COLOR); end
    probe(63, 47, bg, o);
    checks++; if (o !== RECT_COLOR) begin errors++; $display("FAIL border_63_47: got %h expected %h", o, RECT_COLOR); end
    probe(2, 2, bg, o);
    checks++; if (o !== bg) begin errors++; $display("FAIL border_2_2: got %h expected %h", o, bg); end
    probe(30, 20, bg, o);
    checks++; if (o !== bg) begin errors++; $display("FAIL border_30_20: got %h expected %h", o, bg); end
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
`ifdef DRAW_RECT_BORDER_EN
    test_border();
`else
    test_default_rect();
`endif
    test_mid_frame_request();
    test_clamp();
    test_hold_valid();
    test_commit_cycle_accept();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
